player_hit_judge: RTL and testbench
===================================

Name: player_hit_judge

Overview:
Next-generation player collision/damage judge. Checks the player hitbox against NUM_BULLETS enemy bullets in parallel and kills every overlapping bullet. Decrements health once per hit event, grants timed invulnerability after a hit, and sequences the explosion and death. Sits between the enemy-bullet manager (consumes eb_kill) and the renderer/game FSM (consumes health, boom, dead, invincible).

Parameters:
NUM_BULLETS, 4, number of enemy bullet channels checked in parallel
COORD_W, 10, coordinate width
HEALTH_W, 4, health counter width
INIT_HEALTH, 3, health loaded at reset and on revive (must be >0 and fit HEALTH_W)
Y_OFF, 480, added to p_y to form the screen-space player Y
HB_L, 10, hitbox extent left of player x
HB_R, 50, hitbox extent right of player x (exclusive)
HB_U, 50, hitbox extent above player y (inclusive)
HB_D, 40, hitbox extent below player y (exclusive)
IFRAME_TICKS, 60, invulnerability length in frame ticks
BOOM_TICKS, 30, explosion length in frame ticks

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
tick  in  1  one-cycle frame strobe; all timers count ticks
p_x  in  COORD_W  player x
p_y  in  COORD_W  player y (pre-offset)
eb_x  in  NUM_BULLETS*COORD_W  bullet x, channel i at [i*COORD_W +: COORD_W]
eb_y  in  NUM_BULLETS*COORD_W  bullet y, same packing
eb_en  in  NUM_BULLETS  bullet i exists
my_en  in  1  player present; 0 disables all detection
revive  in  1  restart request, honoured only in DEAD
eb_kill  out  NUM_BULLETS  one-cycle pulse per bullet to remove
hit  out  1  one-cycle pulse when damage is applied
health  out  HEALTH_W  current health
invincible  out  1  high in IFRAME
boom  out  1  high in BOOM
dead  out  1  high in DEAD

Behaviour:
- Reset (async): state ALIVE; health=INIT_HEALTH; eb_kill=0; hit=0; timers=0; invincible=boom=dead=0; registered player position cleared to 0.
- Stage 1: p_x and p_y+Y_OFF are registered every cycle (px_r, py_r, width COORD_W+1, no wrap).
- Stage 2: compare against the current-cycle eb_* using px_r/py_r. Overlap test, all unsigned in COORD_W+1 bits:
  - bx >= sat(px_r-HB_L) and bx < px_r+HB_R
  - by >= sat(py_r-HB_U) and by < py_r+HB_D
  - sat() clamps at 0; no wrap-around, unlike the previous generation.
- ovl[i] = eb_en[i] & my_en & overlap_i & (state is ALIVE or IFRAME).
- eb_kill <= ovl, registered, one cycle. A bullet held overlapping re-fires eb_kill each cycle until eb_en drops.
- States:
  - ALIVE:
    - |ovl & health>1: health-1, hit pulse, iframe timer=IFRAME_TICKS, go to IFRAME.
    - |ovl & health==1: health=0, hit pulse, boom timer=BOOM_TICKS, go to BOOM.
    - Several simultaneous overlaps cost exactly 1 health.
  - IFRAME:
    - Overlapping bullets are still killed (absorbed); no damage, no hit.
    - Timer decrements on tick; on tick with timer==1, go to ALIVE.
  - BOOM:
    - No detection.
    - Timer decrements on tick; on tick with timer==1, go to DEAD.
  - DEAD:
    - No detection.
    - revive=1: health=INIT_HEALTH, go to ALIVE.
    - revive outside DEAD is ignored.
- Outputs invincible, boom and dead are registered decodes of the state.
- Latency: p_* change to effective hitbox is 1 cycle; bullet overlap to eb_kill/hit/health update is 1 cycle.
- my_en low: no kills, no damage; timers keep running.
- tick and a hit in the same cycle: the hit wins; the timer loads fresh.
- Reset mid-BOOM or mid-IFRAME: immediate return to the reset state.

Decomposition:
- Package player_hit_pkg: state enum (ALIVE, IFRAME, BOOM, DEAD) and default hitbox constants.
- Sub-module hitbox_cmp: one-channel saturating overlap comparator, instantiated NUM_BULLETS times via generate.
- FSM and timers stay in the top module.

Test Plan:
- p=(100,0)→py_r=480; bullet0=(95,450) en → next cycle eb_kill=0001, hit=1, health 3→2, invincible=1.
- Bullet at x=150 (px_r+HB_R) or y=520 (py_r+HB_D) → no kill. Bullet at x=90, y=430 → kill (inclusive lower bounds).
- In IFRAME, bullet1 overlaps → eb_kill=0010, hit=0, health unchanged. After 60 ticks invincible=0; a fresh overlap hits again.
- Bullets 0, 2 and 3 overlap in the same ALIVE cycle → eb_kill=1101, health-1 only.
- Health=1, hit → health=0, boom=1 for 30 ticks, then dead=1. revive → health=3, ALIVE. revive while boom=1 → ignored.
- p_x=5 (saturated lower bound 0), bullet x=0 → kill. Also: assert rst during BOOM → boom=0, health=3 asynchronously.

Source files
------------

// File: rtl/player_hit_pkg.sv
// player_hit_pkg: state encoding and default hitbox geometry for the player hit judge.
package player_hit_pkg;
  typedef enum logic [1:0] {ALIVE, IFRAME, BOOM, DEAD} state_t;
  localparam int DEF_Y_OFF = 480;
  localparam int DEF_HB_L = 10;
  localparam int DEF_HB_R = 50;
  localparam int DEF_HB_U = 50;
  localparam int DEF_HB_D = 40;
endpackage

// File: rtl/hitbox_cmp.sv
// hitbox_cmp: one-channel overlap test of a bullet against the player hitbox, lower bounds clamped at 0.
module hitbox_cmp #(
  parameter int COORD_W = 10,
  parameter int HB_L = 10,
  parameter int HB_R = 50,
  parameter int HB_U = 50,
  parameter int HB_D = 40
) (
  input  logic [COORD_W:0]   px,
  input  logic [COORD_W:0]   py,
  input  logic [COORD_W-1:0] bx,
  input  logic [COORD_W-1:0] by,
  output logic               ovl
);
  localparam int W = COORD_W + 1;
  logic [W-1:0] l, r, u, d, x, y;
  always_comb begin
    x = {1'b0, bx};
    y = {1'b0, by};
    l = px >= W'(HB_L) ? px - W'(HB_L) : '0;
    u = py >= W'(HB_U) ? py - W'(HB_U) : '0;
    r = px + W'(HB_R);
    d = py + W'(HB_D);
    ovl = x >= l && x < r && y >= u && y < d;
  end
endmodule

// File: rtl/player_hit_judge.sv
// player_hit_judge: parallel bullet/player collision, bullet kills, health, invulnerability and death sequencing.
module player_hit_judge import player_hit_pkg::*; #(
  parameter int NUM_BULLETS = 4,
  parameter int COORD_W = 10,
  parameter int HEALTH_W = 4,
  parameter int INIT_HEALTH = 3,
  parameter int Y_OFF = DEF_Y_OFF,
  parameter int HB_L = DEF_HB_L,
  parameter int HB_R = DEF_HB_R,
  parameter int HB_U = DEF_HB_U,
  parameter int HB_D = DEF_HB_D,
  parameter int IFRAME_TICKS = 60,
  parameter int BOOM_TICKS = 30
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           tick,
  input  logic [COORD_W-1:0]             p_x,
  input  logic [COORD_W-1:0]             p_y,
  input  logic [NUM_BULLETS*COORD_W-1:0] eb_x,
  input  logic [NUM_BULLETS*COORD_W-1:0] eb_y,
  input  logic [NUM_BULLETS-1:0]         eb_en,
  input  logic                           my_en,
  input  logic                           revive,
  output logic [NUM_BULLETS-1:0]         eb_kill,
  output logic                           hit,
  output logic [HEALTH_W-1:0]            health,
  output logic                           invincible,
  output logic                           boom,
  output logic                           dead
);
  localparam int W = COORD_W + 1;
  localparam int TMAX = IFRAME_TICKS > BOOM_TICKS ? IFRAME_TICKS : BOOM_TICKS;
  localparam int TW = $clog2(TMAX + 1);
  state_t state;
  logic [W-1:0] px_r, py_r;
  logic [TW-1:0] timer;
  logic [NUM_BULLETS-1:0] ov, ovl;
  logic active;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      px_r <= '0;
      py_r <= '0;
    end else begin
      px_r <= {1'b0, p_x};
      py_r <= {1'b0, p_y} + W'(Y_OFF);
    end
  for (genvar i = 0; i < NUM_BULLETS; i++) begin : g_cmp
    hitbox_cmp #(
      .COORD_W(COORD_W), .HB_L(HB_L), .HB_R(HB_R), .HB_U(HB_U), .HB_D(HB_D)
    ) u_cmp (
      .px(px_r), .py(py_r),
      .bx(eb_x[i*COORD_W +: COORD_W]), .by(eb_y[i*COORD_W +: COORD_W]),
      .ovl(ov[i])
    );
  end
  assign active = my_en && (state == ALIVE || state == IFRAME);
  assign ovl = eb_en & ov & {NUM_BULLETS{active}};
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= ALIVE;
      health <= HEALTH_W'(INIT_HEALTH);
      timer <= '0;
      eb_kill <= '0;
      hit <= 1'b0;
      invincible <= 1'b0;
      boom <= 1'b0;
      dead <= 1'b0;
    end else begin
      eb_kill <= ovl;
      hit <= 1'b0;
      case (state)
        ALIVE:
          if (|ovl) begin
            hit <= 1'b1;
            if (health > HEALTH_W'(1)) begin
              health <= health - HEALTH_W'(1);
              timer <= TW'(IFRAME_TICKS);
              state <= IFRAME;
              invincible <= 1'b1;
            end else begin
              health <= '0;
              timer <= TW'(BOOM_TICKS);
              state <= BOOM;
              boom <= 1'b1;
            end
          end
        IFRAME:
          if (tick) begin
            timer <= timer - TW'(1);
            if (timer == TW'(1)) begin
              state <= ALIVE;
              invincible <= 1'b0;
            end
          end
        BOOM:
          if (tick) begin
            timer <= timer - TW'(1);
            if (timer == TW'(1)) begin
              state <= DEAD;
              boom <= 1'b0;
              dead <= 1'b1;
            end
          end
        DEAD:
          if (revive) begin
            health <= HEALTH_W'(INIT_HEALTH);
            state <= ALIVE;
            dead <= 1'b0;
          end
      endcase
    end
endmodule

// File: tb/tb_player_hit_judge.sv
// tb_player_hit_judge: directed stimulus with a per-cycle expected-response queue checked by a monitor.
module tb_player_hit_judge;
  logic clk = 0, rst = 0, tick = 0, my_en = 0, revive = 0;
  logic [9:0] p_x = 0, p_y = 0;
  logic [39:0] eb_x = 0, eb_y = 0;
  logic [3:0] eb_en = 0, eb_kill;
  logic hit, invincible, boom, dead;
  logic [3:0] health;
  int checks = 0, errors = 0;
  typedef struct packed {
    logic chk;
    logic [3:0] kill;
    logic hit;
    logic [3:0] health;
    logic inv, boom, dead;
  } exp_t;
  exp_t q[$];

  player_hit_judge dut (
    .clk(clk), .rst(rst), .tick(tick), .p_x(p_x), .p_y(p_y),
    .eb_x(eb_x), .eb_y(eb_y), .eb_en(eb_en), .my_en(my_en), .revive(revive),
    .eb_kill(eb_kill), .hit(hit), .health(health),
    .invincible(invincible), .boom(boom), .dead(dead)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q.size() != 0) begin
      e = q.pop_front();
      if (e.chk) begin
        checks++;
        if ({eb_kill, hit, health, invincible, boom, dead} !=
            {e.kill, e.hit, e.health, e.inv, e.boom, e.dead}) begin
          errors++;
          $display("FAIL step%0d: got kill=%b hit=%b health=%0d inv=%b boom=%b dead=%b, want kill=%b hit=%b health=%0d inv=%b boom=%b dead=%b",
                   checks, eb_kill, hit, health, invincible, boom, dead,
                   e.kill, e.hit, e.health, e.inv, e.boom, e.dead);
        end
      end
    end
  end

  task automatic cyc(input logic c, input logic [3:0] k, input logic h, input logic [3:0] hl,
                     input logic i, input logic b, input logic d);
    q.push_back({c, k, h, hl, i, b, d});
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int n, input logic t);
    tick = t;
    repeat (n) cyc(1'b0, 4'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    tick = 1'b0;
  endtask

  task automatic setb(input int i, input logic [9:0] x, input logic [9:0] y, input logic en);
    eb_x[i*10 +: 10] = x;
    eb_y[i*10 +: 10] = y;
    eb_en[i] = en;
  endtask

  task automatic direct(input string name, input logic [11:0] got, input logic [11:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  initial begin
    #1 rst = 1;
    #7;
    direct("reset_state", {eb_kill, hit, health, invincible, boom, dead}, {4'b0, 1'b0, 4'd3, 3'b000});
    #4 rst = 0;
    @(posedge clk);
    #2;
    p_x = 100; p_y = 0; my_en = 1;
    idle(1, 0);
    setb(0, 95, 450, 1);
    cyc(1, 4'b0001, 1, 2, 1, 0, 0);
    eb_en = 0;
    cyc(1, 4'b0000, 0, 2, 1, 0, 0);
    setb(0, 150, 450, 1);
    cyc(1, 4'b0000, 0, 2, 1, 0, 0);
    setb(0, 100, 520, 1);
    cyc(1, 4'b0000, 0, 2, 1, 0, 0);
    eb_en = 0;
    setb(1, 90, 430, 1);
    cyc(1, 4'b0010, 0, 2, 1, 0, 0);
    eb_en = 0;
    idle(59, 1);
    cyc(1, 4'b0000, 0, 2, 1, 0, 0);
    tick = 1;
    cyc(1, 4'b0000, 0, 2, 0, 0, 0);
    tick = 0;
    setb(0, 100, 450, 1);
    setb(1, 100, 450, 0);
    setb(2, 100, 450, 1);
    setb(3, 100, 450, 1);
    cyc(1, 4'b1101, 1, 1, 1, 0, 0);
    eb_en = 0;
    cyc(1, 4'b0000, 0, 1, 1, 0, 0);
    idle(60, 1);
    cyc(1, 4'b0000, 0, 1, 0, 0, 0);
    my_en = 0;
    setb(0, 100, 450, 1);
    cyc(1, 4'b0000, 0, 1, 0, 0, 0);
    my_en = 1;
    cyc(1, 4'b0001, 1, 0, 0, 1, 0);
    eb_en = 0;
    revive = 1;
    cyc(1, 4'b0000, 0, 0, 0, 1, 0);
    revive = 0;
    idle(28, 1);
    tick = 1;
    cyc(1, 4'b0000, 0, 0, 0, 1, 0);
    cyc(1, 4'b0000, 0, 0, 0, 0, 1);
    tick = 0;
    setb(0, 100, 450, 1);
    cyc(1, 4'b0000, 0, 0, 0, 0, 1);
    revive = 1;
    cyc(1, 4'b0000, 0, 3, 0, 0, 0);
    revive = 0;
    cyc(1, 4'b0001, 1, 2, 1, 0, 0);
    eb_en = 0;
    p_x = 5;
    idle(1, 0);
    setb(0, 0, 450, 1);
    cyc(1, 4'b0001, 0, 2, 1, 0, 0);
    setb(0, 55, 450, 1);
    cyc(1, 4'b0000, 0, 2, 1, 0, 0);
    setb(0, 0, 450, 0);
    idle(60, 1);
    eb_en[0] = 1;
    cyc(1, 4'b0001, 1, 1, 1, 0, 0);
    eb_en = 0;
    idle(60, 1);
    eb_en[0] = 1;
    cyc(1, 4'b0001, 1, 0, 0, 1, 0);
    eb_en = 0;
    idle(5, 1);
    repeat (4) @(posedge clk);
    direct("queue_drained", 12'(q.size()), 12'd0);
    #4 rst = 1;
    #1;
    direct("async_reset_boom", {eb_kill, hit, health, invincible, boom, dead}, {4'b0, 1'b0, 4'd3, 3'b000});
    #3 rst = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
